display_scan_scheduler: RTL and testbench

Sequences the two-digit multiplexed 7-segment display. It time-slices the shared segment bus between digit 0 and digit 1 and inserts blanking gaps between slices to prevent ghosting. New digit data is double-buffered behind a valid/ready handshake and committed only at frame boundaries, so no tearing occurs. It replaces the free-running scan selection ahead of the digit decoder, and its boundedData output feeds that decoder.

---
 rtl/display_scan_scheduler_pkg.sv | 26 ++
 rtl/display_scan_scheduler_if.sv | 17 +
 rtl/display_scan_scheduler_scan_phase_counter.sv | 37 +++
 rtl/display_scan_scheduler.sv | 138 +++++++++++++
 tb/tb_display_scan_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the two-digit display scan scheduler.
//   scan_state_e  : scan phase encoding (BLANK0, SHOW0, BLANK1, SHOW1)
//   COM_*         : active-low digit-enable patterns
//   digit_pair_t  : payload for one committed/pending digit pair
package scan_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned COM_W   = 2;

    typedef enum logic [1:0] {
        ST_BLANK0 = 2'd0,
        ST_SHOW0  = 2'd1,
        ST_BLANK1 = 2'd2,
        ST_SHOW1  = 2'd3
    } scan_state_e;

    localparam logic [COM_W-1:0] COM_OFF = 2'b11;
    localparam logic [COM_W-1:0] COM_D0  = 2'b10;
    localparam logic [COM_W-1:0] COM_D1  = 2'b01;

    typedef struct packed {
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } digit_pair_t;

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Digit-pair write channel (valid/ready).
//   wrValid : writer offers a new digit pair
//   wrReady : scheduler can take it (pending buffer empty)
//   wrData1 : digit 0 value
//   wrData2 : digit 1 value
interface display_scan_scheduler_if;
    import scan_pkg::*;

    logic               wrValid;
    logic               wrReady;
    logic [DIGIT_W-1:0] wrData1;
    logic [DIGIT_W-1:0] wrData2;

    modport master (output wrValid, output wrData1, output wrData2, input wrReady);
    modport slave  (input wrValid, input wrData1, input wrData2, output wrReady);

endinterface

// File: rtl/display_scan_scheduler_scan_phase_counter.sv
// Terminal-count phase counter shared by blank and show phases.
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous return to 0
//   limit       : terminal count (phase length - 1) for the current phase
//   count_nxt_c : value the counter takes at the next edge
//   done_c      : counter sits on its terminal count this cycle
module scan_phase_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count_nxt_c,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;

    // Wrap to zero on terminal count so the next phase starts fresh.
    always_comb begin
        done_c      = (count_q == limit);
        count_nxt_c = count_q + CNT_W'(1);
        if (clear || done_c) begin
            count_nxt_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt_c;
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Two-digit multiplexed 7-segment scan scheduler with blanking gaps and
// frame-synchronous double-buffered digit updates.
//   sysClk, sysRst : clock, async active-low reset
//   enable         : 1 = scanning, 0 = forced dark
//   wr             : digit-pair write channel (slave side)
//   COM            : active-low digit enables
//   boundedData    : value for the digit currently driven
//   blank          : no digit driven
//   frameTick      : pulse on the last cycle of each frame
module display_scan_scheduler
    import scan_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     sysClk,
    input  logic                     sysRst,
    input  logic                     enable,
    display_scan_scheduler_if.slave  wr,
    output logic [COM_W-1:0]         COM,
    output logic [DIGIT_W-1:0]       boundedData,
    output logic                     blank,
    output logic                     frameTick
);

    scan_state_e        state_q;
    scan_state_e        state_d;
    logic [CNT_W-1:0]   limit_c;
    logic [CNT_W-1:0]   cnt_nxt_c;
    logic               done_c;

    logic [COM_W-1:0]   com_d;
    logic [DIGIT_W-1:0] data_d;
    logic               blank_d;
    logic               tick_d;

    digit_pair_t        pending_q;
    digit_pair_t        active_q;
    logic               wr_ready_q;
    logic               accept_c;
    logic               commit_c;

    // Phase length follows the current state.
    assign limit_c = (state_q == ST_SHOW0 || state_q == ST_SHOW1)
                   ? CNT_W'(DIGIT_CYCLES - 1)
                   : CNT_W'(BLANK_CYCLES - 1);

    scan_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk         (sysClk),
        .rst_n       (sysRst),
        .clear       (!enable),
        .limit       (limit_c),
        .count_nxt_c (cnt_nxt_c),
        .done_c      (done_c)
    );

    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            state_q <= ST_BLANK0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the output values that state will present, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d = state_q;
        com_d   = COM_OFF;
        data_d  = '0;
        blank_d = 1'b1;
        tick_d  = 1'b0;

        if (!enable) begin
            state_d = ST_BLANK0;
        end else if (done_c) begin
            unique case (state_q)
                ST_BLANK0: state_d = ST_SHOW0;
                ST_SHOW0:  state_d = ST_BLANK1;
                ST_BLANK1: state_d = ST_SHOW1;
                ST_SHOW1:  state_d = ST_BLANK0;
            endcase
        end

        unique case (state_d)
            ST_SHOW0: begin
                com_d   = COM_D0;
                data_d  = active_q.d0;
                blank_d = 1'b0;
            end
            ST_SHOW1: begin
                com_d   = COM_D1;
                data_d  = active_q.d1;
                blank_d = 1'b0;
                tick_d  = (cnt_nxt_c == CNT_W'(DIGIT_CYCLES - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            COM         <= COM_OFF;
            boundedData <= '0;
            blank       <= 1'b1;
            frameTick   <= 1'b0;
        end else begin
            COM         <= com_d;
            boundedData <= data_d;
            blank       <= blank_d;
            frameTick   <= tick_d;
        end
    end

    // wrReady doubles as "pending empty"; commit needs a full buffer, so a
    // write landing on the tick cycle waits for the following frame.
    assign accept_c   = wr.wrValid && wr_ready_q;
    assign commit_c   = frameTick && enable && !wr_ready_q;
    assign wr.wrReady = wr_ready_q;

    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            pending_q  <= '0;
            active_q   <= '0;
            wr_ready_q <= 1'b1;
        end else if (accept_c) begin
            pending_q  <= '{d1: wr.wrData2, d0: wr.wrData1};
            wr_ready_q <= 1'b0;
        end else if (commit_c) begin
            active_q   <= pending_q;
            wr_ready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

    localparam int unsigned D     = 4;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = 2 * (B + D);
    localparam logic [8:0]  RST_VEC = {2'b11, 1'b1, 4'h0, 1'b0, 1'b1};

    logic       sysClk;
    logic       sysRst;
    logic       enable;
    logic [1:0] COM;
    logic [3:0] boundedData;
    logic       blank;
    logic       frameTick;

    int checks;
    int errors;

    display_scan_scheduler_if wr();

    display_scan_scheduler #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B),
        .CNT_W        (16)
    ) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .enable      (enable),
        .wr          (wr),
        .COM         (COM),
        .boundedData (boundedData),
        .blank       (blank),
        .frameTick   (frameTick)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Reference model: position within the frame plus a one-deep write buffer.
    int unsigned m_t;
    logic [3:0]  m_act0, m_act1, m_pend0, m_pend1;
    logic        m_full;
    logic        m_acc;

    always @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            m_t <= 0; m_act0 <= 0; m_act1 <= 0; m_pend0 <= 0; m_pend1 <= 0;
            m_full <= 1'b0; m_acc <= 1'b0;
        end else begin
            m_acc <= wr.wrValid && !m_full;
            if (wr.wrValid && !m_full) begin
                m_pend0 <= wr.wrData1;
                m_pend1 <= wr.wrData2;
                m_full  <= 1'b1;
            end else if (enable && m_t == FRAME - 1 && m_full) begin
                m_act0 <= m_pend0;
                m_act1 <= m_pend1;
                m_full <= 1'b0;
            end
            m_t <= enable ? (m_t + 1) % FRAME : 0;
        end
    end

    function automatic logic [8:0] exp_vec();
        logic [1:0] com;
        logic       bl;
        logic [3:0] d;
        com = 2'b11; bl = 1'b1; d = 4'h0;
        if (m_t >= B && m_t < B + D) begin
            com = 2'b10; bl = 1'b0; d = m_act0;
        end else if (m_t >= 2 * B + D) begin
            com = 2'b01; bl = 1'b0; d = m_act1;
        end
        return {com, bl, d, 1'(m_t == FRAME - 1), ~m_full};
    endfunction

    function automatic logic [8:0] got_vec();
        return {COM, blank, boundedData, frameTick, wr.wrReady};
    endfunction

    // Never both digits driven at once.
    always @(negedge sysClk) begin
        if (sysRst === 1'b1) begin
            checks++;
            if (COM === 2'b00) begin
                errors++;
                $display("FAIL com_invariant t=%0t: COM=%b must not be 00", $time, COM);
            end
        end
    end

    task automatic do_reset();
        wr.wrValid = 1'b0;
        wr.wrData1 = 4'h0;
        wr.wrData2 = 4'h0;
        enable     = 1'b1;
        sysRst     = 1'b0;
        @(posedge sysClk);
        @(posedge sysClk);
        #1 sysRst = 1'b1;
    endtask

    // Hold an offer until accepted, then optionally present a fresh one.
    task automatic drive_rand(input int pct);
        if (!wr.wrValid || m_acc) begin
            wr.wrValid = ($urandom_range(99) < pct);
            wr.wrData1 = 4'($urandom);
            wr.wrData2 = 4'($urandom);
        end
    endtask

    task automatic test_reset();
        wr.wrValid = 1'b0;
        enable     = 1'b1;
        sysRst     = 1'b0;
        @(posedge sysClk);
        @(negedge sysClk);
        checks++;
        if (got_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", got_vec(), RST_VEC);
        end
        @(posedge sysClk);
        #1 sysRst = 1'b1;
        @(negedge sysClk);
        checks++;
        if (got_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_cycle0: got %b expected %b", got_vec(), RST_VEC);
        end
    endtask

    task automatic test_scan_pattern();
        logic [1:0] ecom;
        do_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL scan_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            ecom = (c % FRAME < 2) ? 2'b11 : (c % FRAME < 6) ? 2'b10 : (c % FRAME < 8) ? 2'b11 : 2'b01;
            checks++;
            if (COM !== ecom || frameTick !== 1'(c % FRAME == 11)) begin
                errors++;
                $display("FAIL scan_table c=%0d: got COM=%b tick=%b expected COM=%b tick=%b",
                         c, COM, frameTick, ecom, 1'(c % FRAME == 11));
            end
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic test_commit();
        do_reset();
        for (int c = 0; c < 2 * FRAME + 2; c++) begin
            if (c == 0) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd3; wr.wrData2 = 4'd7;
            end else if (m_acc) begin
                wr.wrValid = 1'b0;
            end
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL commit_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            if (c == 1 || c == 12 || c == 5 || c == 14 || c == 20) begin
                checks++;
                if ((c == 1  && wr.wrReady !== 1'b0) || (c == 12 && wr.wrReady !== 1'b1) ||
                    (c == 5  && boundedData !== 4'd0) || (c == 14 && boundedData !== 4'd3) ||
                    (c == 20 && boundedData !== 4'd7)) begin
                    errors++;
                    $display("FAIL commit_point c=%0d: got ready=%b data=%0d", c, wr.wrReady, boundedData);
                end
            end
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 0) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd5; wr.wrData2 = 4'd9;
            end else if (c == 2) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd1; wr.wrData2 = 4'd2;
            end else if (m_acc) begin
                wr.wrValid = 1'b0;
            end
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            if (c == 13 || c == 15 || c == 20 || c == 27 || c == 32) begin
                checks++;
                if ((c == 13 && wr.wrReady !== 1'b0) || (c == 15 && boundedData !== 4'd5) ||
                    (c == 20 && boundedData !== 4'd9) || (c == 27 && boundedData !== 4'd1) ||
                    (c == 32 && boundedData !== 4'd2)) begin
                    errors++;
                    $display("FAIL b2b_point c=%0d: got ready=%b data=%0d", c, wr.wrReady, boundedData);
                end
            end
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic test_write_on_tick();
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 11) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd6; wr.wrData2 = 4'd8;
            end else if (m_acc) begin
                wr.wrValid = 1'b0;
            end
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL tick_write_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            if (c == 12 || c == 14 || c == 23 || c == 26 || c == 32) begin
                checks++;
                if ((c == 12 && wr.wrReady !== 1'b0) || (c == 14 && boundedData !== 4'd0) ||
                    (c == 23 && frameTick !== 1'b1) || (c == 26 && boundedData !== 4'd6) ||
                    (c == 32 && boundedData !== 4'd8)) begin
                    errors++;
                    $display("FAIL tick_write_point c=%0d: got ready=%b tick=%b data=%0d",
                             c, wr.wrReady, frameTick, boundedData);
                end
            end
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            enable = !(c >= 21 && c <= 25);
            if (c == 0) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd4; wr.wrData2 = 4'd5;
            end else if (m_acc) begin
                wr.wrValid = 1'b0;
            end
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL enable_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            if (c == 22 || c == 23 || c == 27 || c == 28 || c == 34) begin
                checks++;
                if ((c == 22 && (COM !== 2'b11 || blank !== 1'b1)) || (c == 23 && frameTick !== 1'b0) ||
                    (c == 27 && COM !== 2'b11) || (c == 28 && (COM !== 2'b10 || boundedData !== 4'd4)) ||
                    (c == 34 && boundedData !== 4'd5)) begin
                    errors++;
                    $display("FAIL enable_point c=%0d: got COM=%b blank=%b tick=%b data=%0d",
                             c, COM, blank, frameTick, boundedData);
                end
            end
            @(posedge sysClk);
            #1;
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                wr.wrValid = 1'b1; wr.wrData1 = 4'd3; wr.wrData2 = 4'd7;
            end else if (m_acc) begin
                wr.wrValid = 1'b0;
            end
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL areset_pre c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            if (c < 15) begin
                @(posedge sysClk);
                #1;
            end
        end
        #2 sysRst = 1'b0;
        #1;
        checks++;
        if (got_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL areset_immediate: got %b expected %b", got_vec(), RST_VEC);
        end
        @(posedge sysClk);
        #1 sysRst = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec() || (c == 3 && boundedData !== 4'd0)) begin
                errors++;
                $display("FAIL areset_post c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 3) enable = ~enable;
            drive_rand(30);
            @(negedge sysClk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d: got %b expected %b", c, got_vec(), exp_vec());
            end
            @(posedge sysClk);
            #1;
        end
        enable = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        enable = 1'b1;
        sysRst = 1'b0;
        wr.wrValid = 1'b0;
        wr.wrData1 = 4'h0;
        wr.wrData2 = 4'h0;
        test_reset();
        test_scan_pattern();
        test_commit();
        test_back_to_back();
        test_write_on_tick();
        test_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
